// File: rtl/controller_pkg.sv
// controller_pkg
//   Shared definitions for the multi-cycle RV32I control unit: RV32I major
//   opcodes, FSM state encoding (also visible on the state_o debug port),
//   trap cause encoding and the ALUOp/UIOp encodings the datapath expects.
package controller_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } trap_cause_t;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [1:0] UIOP_NONE  = 2'b00;
  localparam logic [1:0] UIOP_LUI   = 2'b01;
  localparam logic [1:0] UIOP_AUIPC = 2'b10;

endpackage

// File: rtl/opcode_decode.sv
// opcode_decode
//   Purely combinational decode of a 7-bit RV32I opcode into the static
//   datapath control set, instruction-class flags for the sequencer, and an
//   illegal-opcode flag.
// Ports
//   op_i          in  7  opcode to decode
//   alu_src_o     out 1  ALU operand B takes the immediate
//   mem_to_reg_o  out 1  write-back data comes from memory
//   jalr_sel_o    out 1  jump target is rs1+imm
//   jal_signal_o  out 1  write-back data is OldPC+4
//   branch_o      out 1  control-transfer instruction
//   ui_op_o       out 2  01 LUI, 10 AUIPC
//   alu_op_o      out 2  00 ld/st, 01 branch, 10 R/I, 11 jal/jalr
//   is_*_o        out 1  instruction class flags for the FSM
//   illegal_o     out 1  opcode not supported by this core
module opcode_decode
  import controller_pkg::*;
#(
  parameter bit EN_SYSTEM = 1'b0
) (
  input  logic [6:0] op_i,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       jalr_sel_o,
  output logic       jal_signal_o,
  output logic       branch_o,
  output logic [1:0] ui_op_o,
  output logic [1:0] alu_op_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jump_o,
  output logic       is_system_o,
  output logic       illegal_o
);

  always_comb begin
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    jalr_sel_o   = 1'b0;
    jal_signal_o = 1'b0;
    branch_o     = 1'b0;
    ui_op_o      = UIOP_NONE;
    alu_op_o     = ALUOP_LDST;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_branch_o  = 1'b0;
    is_jump_o    = 1'b0;
    is_system_o  = 1'b0;
    illegal_o    = 1'b0;
    case (op_i)
      OP_REG: begin
        alu_op_o = ALUOP_RI;
      end
      OP_IMM: begin
        alu_src_o = 1'b1;
        alu_op_o  = ALUOP_RI;
      end
      OP_LUI: begin
        alu_src_o = 1'b1;
        ui_op_o   = UIOP_LUI;
      end
      OP_AUIPC: begin
        alu_src_o = 1'b1;
        ui_op_o   = UIOP_AUIPC;
      end
      OP_LOAD: begin
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
        is_load_o    = 1'b1;
      end
      OP_STORE: begin
        alu_src_o  = 1'b1;
        is_store_o = 1'b1;
      end
      OP_BRANCH: begin
        branch_o    = 1'b1;
        alu_op_o    = ALUOP_BRANCH;
        is_branch_o = 1'b1;
      end
      OP_JAL: begin
        branch_o     = 1'b1;
        jal_signal_o = 1'b1;
        alu_op_o     = ALUOP_JUMP;
        is_jump_o    = 1'b1;
      end
      OP_JALR: begin
        alu_src_o    = 1'b1;
        branch_o     = 1'b1;
        jalr_sel_o   = 1'b1;
        jal_signal_o = 1'b1;
        alu_op_o     = ALUOP_JUMP;
        is_jump_o    = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        // Without system support these are simply unknown opcodes.
        if (EN_SYSTEM) is_system_o = 1'b1;
        else           illegal_o   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB for
//   each instruction, talks to instruction and data memories over req/ack,
//   drives the datapath control set plus PC/IR write enables, and halts in a
//   sticky TRAP state on an illegal opcode or a memory timeout.
//
//   Memory handshake: a request (imem_req/dmem_req) is held high, unchanged,
//   until the cycle in which the matching ack is high; that cycle completes
//   the transfer. An ack seen while the request is low has no effect.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   Opcode      in  7     instr[6:0] from IR, valid from DECODE onward
//   imem_ack    in  1     instruction word valid this cycle
//   dmem_ack    in  1     data access complete this cycle
//   imem_req    out 1     instruction fetch request
//   dmem_req    out 1     data memory request
//   IRWrite     out 1     load IR/OldPC (pulse)
//   PCWrite     out 1     update PC (pulse)
//   ALUSrc, MemtoReg, JalrSel, jal_signal, Branch, UIOp, ALUOp
//                         static controls decoded from the latched opcode
//   RegWrite, MemRead, MemWrite
//                         decoded and qualified by the current state
//   trap, trap_cause      sticky halt flag and its cause
//   state_o     out 3     current FSM state (debug)
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1),
  parameter bit EN_SYSTEM      = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] Opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       JalrSel,
  output logic       jal_signal,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] UIOp,
  output logic [1:0] ALUOp,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  // A disabled timeout still needs a 1-bit counter to keep widths legal.
  localparam int              CNT_W      = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  trap_cause_t      cause_q, cause_d;
  // Low while in reset and until the first clock after release, so no
  // request is raised during reset.
  logic             run_q;

  logic [6:0] dec_op;
  logic       dec_load, dec_store, dec_branch, dec_jump, dec_system, dec_illegal;
  logic       timeout_hit;

  // In DECODE the opcode is judged straight from the IR; afterwards the
  // latched copy drives the static controls.
  assign dec_op = (state_q == DECODE) ? Opcode : op_q;

  opcode_decode #(.EN_SYSTEM(EN_SYSTEM)) u_decode (
    .op_i         (dec_op),
    .alu_src_o    (ALUSrc),
    .mem_to_reg_o (MemtoReg),
    .jalr_sel_o   (JalrSel),
    .jal_signal_o (jal_signal),
    .branch_o     (Branch),
    .ui_op_o      (UIOp),
    .alu_op_o     (ALUOp),
    .is_load_o    (dec_load),
    .is_store_o   (dec_store),
    .is_branch_o  (dec_branch),
    .is_jump_o    (dec_jump),
    .is_system_o  (dec_system),
    .illegal_o    (dec_illegal)
  );

  // This waiting cycle is the TIMEOUT_CYCLES-th one without an ack.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (state_q)
      FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            IRWrite = 1'b1;
            state_d = DECODE;
          end else begin
            cnt_d = cnt_inc;
            if (timeout_hit) begin
              state_d = TRAP;
              cause_d = CAUSE_IMEM_TO;
            end
          end
        end
      end
      DECODE: begin
        op_d = Opcode;
        if (dec_illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_load || dec_store) begin
          state_d = MEM;
        end else if (dec_branch) begin
          PCWrite = 1'b1;
          state_d = FETCH;
        end else if (dec_jump) begin
          // PC takes the jump target now; WB only writes the link register.
          PCWrite = 1'b1;
          state_d = WB;
        end else if (dec_system) begin
          PCWrite = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        MemRead  = dec_load;
        MemWrite = dec_store;
        if (dmem_ack) begin
          if (dec_load) begin
            state_d = WB;
          end else begin
            PCWrite = 1'b1;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = TRAP;
            cause_d = CAUSE_DMEM_TO;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = !dec_jump;
        state_d  = FETCH;
      end
      TRAP: begin
        // Halted; only reset leaves this state.
      end
      default: state_d = FETCH;
    endcase
    // Each new memory access gets a fresh timeout budget.
    if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      op_q    <= 7'd0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
    end
  end

  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed and randomized stimulus for multicycle_controller with a
//   timeout of 4 cycles and system instructions disabled. Each instruction
//   is summarized (cycle count, strobe counts, static controls) and compared
//   with a per-opcode reference table.
module tb_multicycle_controller;
  import controller_pkg::*;

  localparam int TO = 4;

  // Reference opcodes, written independently of the design package.
  localparam logic [6:0] R_ADD   = 7'b0110011;
  localparam logic [6:0] R_ADDI  = 7'b0010011;
  localparam logic [6:0] R_LUI   = 7'b0110111;
  localparam logic [6:0] R_AUIPC = 7'b0010111;
  localparam logic [6:0] R_LW    = 7'b0000011;
  localparam logic [6:0] R_SW    = 7'b0100011;
  localparam logic [6:0] R_BEQ   = 7'b1100011;
  localparam logic [6:0] R_JAL   = 7'b1101111;
  localparam logic [6:0] R_JALR  = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, IRWrite, PCWrite;
  logic       ALUSrc, MemtoReg, JalrSel, jal_signal, Branch;
  logic       RegWrite, MemRead, MemWrite, trap;
  logic [1:0] UIOp, ALUOp, trap_cause;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  int   cyc, n_ir, n_rw, n_pc, n_mr, n_mw, n_brpc, n_jw;
  logic trapped, done;

  logic [6:0] ops [9];

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .EN_SYSTEM(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Opcode     (Opcode),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .JalrSel    (JalrSel),
    .jal_signal (jal_signal),
    .Branch     (Branch),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .UIOp       (UIOp),
    .ALUOp      (ALUOp),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycles per instruction with zero-wait memories.
  function automatic int ref_base(input logic [6:0] op);
    if (op == R_BEQ) return 3;
    if (op == R_LW)  return 5;
    return 4;
  endfunction

  // {ALUSrc, MemtoReg, JalrSel, jal_signal, Branch, UIOp[1:0], ALUOp[1:0]}
  function automatic logic [8:0] ref_static(input logic [6:0] op);
    case (op)
      R_ADD:   return 9'b0_0_0_0_0_00_10;
      R_ADDI:  return 9'b1_0_0_0_0_00_10;
      R_LUI:   return 9'b1_0_0_0_0_01_00;
      R_AUIPC: return 9'b1_0_0_0_0_10_00;
      R_LW:    return 9'b1_1_0_0_0_00_00;
      R_SW:    return 9'b1_0_0_0_0_00_00;
      R_BEQ:   return 9'b0_0_0_0_1_00_01;
      R_JAL:   return 9'b0_0_0_1_1_00_11;
      R_JALR:  return 9'b1_0_1_1_1_00_11;
      default: return 9'b0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  // Entered and left just after a falling edge. Acts as both memories:
  // the fetch is acked after iwait refused request cycles and the data
  // access after dwait; while a request is low its ack is random noise.
  task automatic run_instr(input logic [6:0] op, input int iwait, input int dwait);
    int   ireq, dreq;
    logic seen_ir;
    ireq = 0; dreq = 0; seen_ir = 1'b0;
    cyc = 0; n_ir = 0; n_rw = 0; n_pc = 0; n_mr = 0; n_mw = 0; n_brpc = 0; n_jw = 0;
    trapped = 1'b0; done = 1'b0;
    Opcode = 7'($urandom);
    for (int k = 0; k < 64; k++) begin
      imem_ack = imem_req ? (ireq == iwait) : 1'($urandom_range(0, 1));
      dmem_ack = dmem_req ? (dreq == dwait) : 1'($urandom_range(0, 1));
      if (imem_req) ireq++;
      if (dmem_req) dreq++;
      #1;
      if (IRWrite)  n_ir++;
      if (RegWrite) n_rw++;
      if (PCWrite)  n_pc++;
      if (MemRead)  n_mr++;
      if (MemWrite) n_mw++;
      if (PCWrite && Branch)    n_brpc++;
      if (RegWrite && jal_signal) n_jw++;
      if (IRWrite) begin
        seen_ir = 1'b1;
        Opcode  = op;
      end
      cyc++;
      @(negedge clk);
      if (trap) begin
        trapped = 1'b1;
        done    = 1'b1;
        break;
      end
      if (seen_ir && imem_req) begin
        done = 1'b1;
        break;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("cycle_budget", 32'(done), 32'd1);
  endtask

  task automatic check_instr(input logic [6:0] op, input int iwait, input int dwait);
    logic is_mem;
    is_mem = (op == R_LW) || (op == R_SW);
    run_instr(op, iwait, dwait);
    chk($sformatf("latency op=%b", op), cyc, ref_base(op) + iwait + (is_mem ? dwait : 0));
    chk($sformatf("no_trap op=%b", op), 32'(trapped), 32'd0);
    chk($sformatf("irwrite op=%b", op), n_ir, 1);
    chk($sformatf("pcwrite op=%b", op), n_pc, 1);
    chk($sformatf("regwrite op=%b", op), n_rw, ((op == R_BEQ) || (op == R_SW)) ? 0 : 1);
    chk($sformatf("memread op=%b", op), n_mr, (op == R_LW) ? dwait + 1 : 0);
    chk($sformatf("memwrite op=%b", op), n_mw, (op == R_SW) ? dwait + 1 : 0);
    chk($sformatf("pc_with_branch op=%b", op), n_brpc,
        ((op == R_BEQ) || (op == R_JAL) || (op == R_JALR)) ? 1 : 0);
    chk($sformatf("link_writeback op=%b", op), n_jw,
        ((op == R_JAL) || (op == R_JALR)) ? 1 : 0);
    chk($sformatf("static_ctrl op=%b", op),
        32'({ALUSrc, MemtoReg, JalrSel, jal_signal, Branch, UIOp, ALUOp}),
        32'(ref_static(op)));
  endtask

  // Entered just after a falling edge, leaves one cycle after release.
  task automatic do_reset();
    #1;
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("reset_strobes",
        32'({imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemRead, MemWrite}), 32'd0);
    chk("reset_trap", 32'({trap, trap_cause}), 32'd0);
    chk("reset_state", 32'(state_o), 32'(FETCH));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("req_before_first_clock", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("req_after_first_clock", 32'(imem_req), 32'd1);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic bad;
    ops = '{R_ADD, R_ADDI, R_LUI, R_AUIPC, R_LW, R_SW, R_BEQ, R_JAL, R_JALR};

    do_reset();

    // zero-wait addi, delayed lw, beq then jal, ack in the expiry cycle
    check_instr(R_ADDI, 0, 0);
    check_instr(R_LW, 0, 3);
    check_instr(R_BEQ, 0, 0);
    check_instr(R_JAL, 0, 0);
    check_instr(R_LW, 1, TO - 1);
    check_instr(R_SW, TO - 1, 0);

    for (int n = 0; n < 40; n++) begin
      check_instr(ops[$urandom_range(0, 8)], $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    // illegal opcode: trap, stays halted, reset recovers
    run_instr(7'b1111111, 0, 0);
    chk("illegal_trap", 32'(trapped), 32'd1);
    chk("illegal_latency", cyc, 2);
    chk("illegal_cause", 32'(trap_cause), 32'b01);
    bad = 1'b0;
    repeat (5) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (imem_req || dmem_req || PCWrite || RegWrite || MemWrite || !trap) bad = 1'b1;
    end
    chk("trap_halted", 32'(bad), 32'd0);
    do_reset();
    check_instr(R_ADD, 0, 0);

    // SYSTEM is illegal when system support is disabled
    run_instr(7'b1110011, 0, 0);
    chk("system_trap", 32'({trapped, trap_cause}), 32'b1_01);
    do_reset();

    // instruction memory never acks
    run_instr(R_ADDI, 99, 0);
    chk("imem_to_trap", 32'(trapped), 32'd1);
    chk("imem_to_cycles", cyc, TO);
    chk("imem_to_irwrite", n_ir, 0);
    chk("imem_to_cause", 32'(trap_cause), 32'b10);
    do_reset();

    // data memory never acks
    run_instr(R_LW, 0, 99);
    chk("dmem_to_trap", 32'(trapped), 32'd1);
    chk("dmem_to_cycles", cyc, 3 + TO);
    chk("dmem_to_memread", n_mr, TO);
    chk("dmem_to_regwrite", n_rw, 0);
    chk("dmem_to_cause", 32'(trap_cause), 32'b11);
    do_reset();

    // reset asserted while a store waits in MEM
    Opcode   = R_SW;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sw_mem_strobes", 32'({dmem_req, MemWrite}), 32'b11);
    reset_n = 1'b0;
    #1;
    chk("async_drop", 32'({dmem_req, MemWrite, imem_req}), 32'd0);
    chk("async_state", 32'(state_o), 32'(FETCH));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("fetch_after_release", 32'({imem_req, state_o}), 32'({1'b1, FETCH}));
    check_instr(R_JALR, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
